multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS-subset CPU datapath: PC, instruction memory, register file, ALU, sign/zero extender and the PC-source mux. Replaces the single-cycle combinational decoder with a five-state FSM. Each instruction is split into fetch, decode, execute and write-back cycles, so the ALU and adder can be shared and instruction memory can take variable latency through a req/ack handshake. An optional block retires performance counters.

---
 rtl/multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Five-state control sequencer for the multi-cycle MIPS-subset datapath.
// Each instruction runs as fetch, decode, execute and (for R/I-type) write-back,
// so the datapath can share one ALU. Instruction memory may take any number of
// cycles through the mem_req_o/mem_ack_i handshake.
//
// Optional feature: define MCTRL_PERF_CNT_EN to build the performance counters.
// Without it, cycle_cnt_o and instr_cnt_o are tied to 0.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   run_i              start/continue; sampled in IDLE and at retirement
//   instr_op_i         opcode from the instruction register
//   zero_i             ALU zero flag (BEQ decision in EXEC)
//   mem_ack_i          instruction-memory acknowledge
//   mem_req_o          fetch request, held until acknowledged
//   ir_write_o         load instruction register
//   pc_write_o         load PC
//   pc_src_o           0: PC+4, 1: branch target register
//   reg_write_o        register-file write enable
//   reg_dst_o          0: rt, 1: rd
//   alu_src_a_o        0: PC, 1: RS data
//   alu_src_b_o        0: RT, 1: 4, 2: imm, 3: imm<<2
//   alu_op_o           0 add, 1 sub, 2 funct, 3 slt, 4 or
//   zero_ext_o         1: zero-extend immediate, 0: sign-extend
//   illegal_o          one-cycle pulse on an unsupported opcode
//   state_o            current state encoding
//   cycle_cnt_o        active (non-IDLE) cycle count
//   instr_cnt_o        retired instruction count
//
// state  | meaning
// IDLE   | stopped, waiting for run_i
// FETCH  | request instruction, load IR and PC+4 on ack
// DECODE | compute branch target (PC + imm<<2)
// EXEC   | ALU operation; BEQ and illegal opcodes retire here
// WB     | register-file write; R/I-type retire here
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [5:0]       instr_op_i,
    input  logic             zero_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic             zero_ext_o,
    output logic             illegal_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    state_t     state_q, state_d;
    logic       retire;

    // Opcode decode shared by EXEC and WB; the IR is stable across both,
    // so WB re-decodes instead of storing the selects.
    logic       dec_beq;
    logic       dec_legal;
    logic       dec_reg_dst;
    logic       dec_zext;
    logic [1:0] dec_src_b;
    logic [2:0] dec_alu_op;

    always_comb begin
        dec_beq     = 1'b0;
        dec_legal   = 1'b1;
        dec_reg_dst = 1'b0;
        dec_zext    = 1'b0;
        dec_src_b   = 2'd0;
        dec_alu_op  = 3'd0;
        case (instr_op_i)
            OP_RTYPE: begin
                dec_alu_op  = 3'd2;
                dec_reg_dst = 1'b1;
            end
            OP_ADDI: begin
                dec_src_b  = 2'd2;
                dec_alu_op = 3'd0;
            end
            OP_SLTI: begin
                dec_src_b  = 2'd2;
                dec_alu_op = 3'd3;
            end
            OP_ORI: begin
                dec_src_b  = 2'd2;
                dec_alu_op = 3'd4;
                dec_zext   = 1'b1;
            end
            OP_BEQ: begin
                dec_beq    = 1'b1;
                dec_alu_op = 3'd1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        mem_req_o   = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = 1'b0;
        reg_write_o = 1'b0;
        reg_dst_o   = 1'b0;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 2'd0;
        alu_op_o    = 3'd0;
        zero_ext_o  = 1'b0;
        illegal_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'd1;
                // IR load and PC+4 commit in the ack cycle itself.
                if (mem_ack_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
                state_d     = S_EXEC;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = dec_src_b;
                alu_op_o    = dec_alu_op;
                zero_ext_o  = dec_zext;
                reg_dst_o   = dec_reg_dst;
                if (dec_beq) begin
                    pc_src_o   = 1'b1;
                    pc_write_o = zero_i;
                    retire     = 1'b1;
                end else if (!dec_legal) begin
                    illegal_o  = 1'b1;
                    retire     = 1'b1;
                end else begin
                    state_d    = S_WB;
                end
            end
            S_WB: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = dec_src_b;
                alu_op_o    = dec_alu_op;
                zero_ext_o  = dec_zext;
                reg_dst_o   = dec_reg_dst;
                reg_write_o = 1'b1;
                retire      = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            state_d = run_i ? S_FETCH : S_IDLE;
        end
    end

    assign state_o = state_q;

`ifdef MCTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] instr_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_IDLE) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
            if (retire) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign cycle_cnt_o   = '0;
    assign instr_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;
`ifdef MCTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             run_i;
    logic [5:0]       instr_op_i;
    logic             zero_i;
    logic             mem_ack_i;
    logic             mem_req_o, ir_write_o, pc_write_o, pc_src_o;
    logic             reg_write_o, reg_dst_o, alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [2:0]       alu_op_o;
    logic             zero_ext_o, illegal_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] cycle_cnt_o, instr_cnt_o;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .instr_op_i(instr_op_i),
        .zero_i(zero_i), .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
        .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .zero_ext_o(zero_ext_o),
        .illegal_o(illegal_o), .state_o(state_o), .cycle_cnt_o(cycle_cnt_o),
        .instr_cnt_o(instr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0] st;
        logic       req, irw, pcw, pcs, rw, rd, sa;
        logic [1:0] sb;
        logic [2:0] op;
        logic       ze, ill;
    } exp_t;

    // Instruction-level directed vectors with hand-derived totals.
    typedef struct {
        logic [5:0] op;
        int         lat;
        logic       z;
        logic       run_after;
        int         len;   // cycles from first FETCH to retirement
        int         req;   // cycles with mem_req_o
        int         regw;
        int         pcw;
        int         ill;
    } vec_t;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [3:0] m_cyc = 4'd0;
    logic [3:0] m_ins = 4'd0;
    bit         in_fetch = 1'b0;
    int         o_len, o_req, o_rw, o_pcw, o_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t e_idle();
        exp_t e = '0;
        return e;
    endfunction

    function automatic exp_t e_fetch(logic ack);
        exp_t e = '0;
        e.st = 3'd1; e.req = 1'b1; e.sb = 2'd1; e.irw = ack; e.pcw = ack;
        return e;
    endfunction

    function automatic exp_t e_decode();
        exp_t e = '0;
        e.st = 3'd2; e.sb = 2'd3;
        return e;
    endfunction

    function automatic exp_t e_exec(logic [5:0] op, logic z);
        exp_t e = '0;
        e.st = 3'd3; e.sa = 1'b1;
        case (op)
            6'h00: begin e.op = 3'd2; e.rd = 1'b1; end
            6'h08: begin e.sb = 2'd2; e.op = 3'd0; end
            6'h0A: begin e.sb = 2'd2; e.op = 3'd3; end
            6'h0D: begin e.sb = 2'd2; e.op = 3'd4; e.ze = 1'b1; end
            6'h04: begin e.op = 3'd1; e.pcs = 1'b1; e.pcw = z; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic exp_t e_wb(logic [5:0] op);
        exp_t e = e_exec(op, 1'b0);
        e.st = 3'd4; e.rw = 1'b1;
        return e;
    endfunction

    function automatic bit writes_reg(logic [5:0] op);
        return op == 6'h00 || op == 6'h08 || op == 6'h0A || op == 6'h0D;
    endfunction

    // One clock cycle: drive, check at negedge, advance past posedge.
    task automatic cyc(input logic run, input logic [5:0] op, input logic z,
                       input logic ack, input exp_t e, input bit ret);
        exp_t a;
        run_i = run; instr_op_i = op; zero_i = z; mem_ack_i = ack;
        @(negedge clk_i);
        a = {state_o, mem_req_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o,
             reg_dst_o, alu_src_a_o, alu_src_b_o, alu_op_o, zero_ext_o, illegal_o};
        chk("outputs", 32'(a), 32'(e));
        chk("counters", 32'({cycle_cnt_o, instr_cnt_o}),
            32'(PERF ? {m_cyc, m_ins} : 8'h00));
        o_len += (e.st != 3'd0) ? 1 : 0;
        o_req += int'(mem_req_o);
        o_rw  += int'(reg_write_o);
        o_pcw += int'(pc_write_o);
        o_ill += int'(illegal_o);
        @(posedge clk_i);
        #1;
        if (e.st != 3'd0) m_cyc = m_cyc + 4'd1;
        if (ret) m_ins = m_ins + 4'd1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int lat, input logic z,
                             input logic run_after);
        logic zz;
        if (!in_fetch) cyc(1'b1, 6'($urandom), 1'($urandom), 1'($urandom), e_idle(), 1'b0);
        o_len = 0; o_req = 0; o_rw = 0; o_pcw = 0; o_ill = 0;
        for (int k = 1; k <= lat; k++)
            cyc(1'($urandom), 6'($urandom), 1'($urandom), k == lat, e_fetch(k == lat), 1'b0);
        cyc(1'($urandom), op, 1'($urandom), 1'($urandom), e_decode(), 1'b0);
        if (writes_reg(op)) begin
            zz = 1'($urandom);
            cyc(1'($urandom), op, zz, 1'($urandom), e_exec(op, zz), 1'b0);
            cyc(run_after, op, 1'($urandom), 1'($urandom), e_wb(op), 1'b1);
        end else begin
            zz = (op == 6'h04) ? z : 1'($urandom);
            cyc(run_after, op, zz, 1'($urandom), e_exec(op, zz), 1'b1);
        end
        in_fetch = run_after;
    endtask

    vec_t vecs[7];
    logic [5:0] rop;

    initial begin
        vecs[0] = '{6'h08, 1, 1'b0, 1'b1, 4, 1, 1, 1, 0};
        vecs[1] = '{6'h00, 3, 1'b0, 1'b1, 6, 3, 1, 1, 0};
        vecs[2] = '{6'h0A, 2, 1'b1, 1'b1, 5, 2, 1, 1, 0};
        vecs[3] = '{6'h0D, 1, 1'b0, 1'b1, 4, 1, 1, 1, 0};
        vecs[4] = '{6'h04, 1, 1'b1, 1'b1, 3, 1, 0, 2, 0};
        vecs[5] = '{6'h04, 2, 1'b0, 1'b1, 4, 2, 0, 1, 0};
        vecs[6] = '{6'h23, 1, 1'b0, 1'b0, 3, 1, 0, 1, 1};

        rst_i = 1'b1; run_i = 1'b1; instr_op_i = 6'h00; zero_i = 1'b0; mem_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        cyc(1'b1, 6'h08, 1'b0, 1'b0, e_idle(), 1'b0);
        rst_i = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_instr(vecs[i].op, vecs[i].lat, vecs[i].z, vecs[i].run_after);
            chk($sformatf("v%0d_len", i), 32'(o_len), 32'(vecs[i].len));
            chk($sformatf("v%0d_req", i), 32'(o_req), 32'(vecs[i].req));
            chk($sformatf("v%0d_regw", i), 32'(o_rw), 32'(vecs[i].regw));
            chk($sformatf("v%0d_pcw", i), 32'(o_pcw), 32'(vecs[i].pcw));
            chk($sformatf("v%0d_ill", i), 32'(o_ill), 32'(vecs[i].ill));
        end
        // Stopped at retirement of the illegal opcode: stays in IDLE.
        cyc(1'b0, 6'h08, 1'b0, 1'b1, e_idle(), 1'b0);
        chk("stop_state", 32'(state_o), 32'd0);

        // Reset while FETCH is waiting for ack
        cyc(1'b1, 6'h08, 1'b0, 1'b0, e_idle(), 1'b0);
        cyc(1'b1, 6'h08, 1'b0, 1'b0, e_fetch(1'b0), 1'b0);
        rst_i = 1'b1;
        cyc(1'b1, 6'h08, 1'b0, 1'b0, e_fetch(1'b0), 1'b0);
        rst_i = 1'b0;
        m_cyc = 4'd0; m_ins = 4'd0; in_fetch = 1'b0;
        cyc(1'b0, 6'h08, 1'b0, 1'b1, e_idle(), 1'b0);
        chk("rst_fetch_req", 32'(mem_req_o), 32'd0);

        // 16 retirements wrap a 4-bit instruction counter back to 0
        for (int i = 0; i < 16; i++) run_instr(6'h08, 1, 1'b0, i != 15);
        @(negedge clk_i);
        chk("instr_cnt_wrap", 32'(instr_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: rop = 6'h00;
                1: rop = 6'h08;
                2: rop = 6'h0A;
                3: rop = 6'h0D;
                4: rop = 6'h04;
                default: rop = 6'($urandom);
            endcase
            run_instr(rop, int'($urandom_range(1, 4)), 1'($urandom),
                      ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
